// File: rtl/mc_incn_r_pkg.sv
// Shared memory-controller constants used by the incrementer and its users.
package mc_incn_r_pkg;

    // Default operand width of the registered incrementer
    localparam int MC_INCN_DEFAULT_W = 32;

    // Width of the async-device (ACS) burst address counter in the address selector
    localparam int MC_ACS_ADDR_W = 24;

endpackage : mc_incn_r_pkg

// File: rtl/mc_incn_r.sv
// Registered N-bit incrementer: inc_out = inc_in + 1 (mod 2^incN_width), one
// clock of latency. inc_in must stay stable for a full cycle before inc_out is
// sampled.
//
// Build option MC_INCN_FULL_REG_EN:
//   undefined - split pipeline. The lower half and its carry-out are
//               registered. The upper half is added combinationally from
//               inc_in using the registered carry. Reset clears only the
//               lower register, so the upper input bits still pass through.
//   defined   - the whole sum is registered. There is no combinational path
//               from inc_in to inc_out, and reset clears every output bit.
module mc_incn_r
    import mc_incn_r_pkg::*;
#(
    parameter int incN_width = MC_INCN_DEFAULT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [incN_width-1:0] inc_in,
    output logic [incN_width-1:0] inc_out
);

`ifdef MC_INCN_FULL_REG_EN

    logic [incN_width-1:0] out_d;
    logic [incN_width-1:0] out_q;

    // Full-width next sum; wraps to zero on all-ones input
    always_comb begin
        out_d = inc_in + incN_width'(1);
    end

    // Register the complete result; reset takes priority over the load
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign inc_out = out_q;

`else

    // Split point: lower C bits are registered, the remaining bits form the upper part
    localparam int C    = incN_width / 2;
    localparam int HI_W = incN_width - C;

    logic [C:0]      lo_d;   // bit C is the carry out of the lower half
    logic [C:0]      lo_q;
    logic [HI_W-1:0] hi;

    // Lower-half increment, widened by one bit to capture the carry
    always_comb begin
        lo_d = {1'b0, inc_in[C-1:0]} + (C+1)'(1);
    end

    // Load the lower sum every edge; reset takes priority over the load
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
        end else begin
            lo_q <= lo_d;
        end
    end

    // Upper half uses the live inc_in bits plus the registered carry, truncated to HI_W
    always_comb begin
        hi = inc_in[incN_width-1:C] + HI_W'(lo_q[C]);
    end

    assign inc_out = {hi, lo_q[C-1:0]};

`endif

endmodule : mc_incn_r

// File: tb/tb_mc_incn_r.sv
// Directed bench for mc_incn_r at the ACS address width (24 bits, split at 12).
// Expected values hold for either build; the few that differ under
// MC_INCN_FULL_REG_EN are selected with the same macro.
module tb_mc_incn_r;
    import mc_incn_r_pkg::*;

    localparam int W = MC_ACS_ADDR_W;

    logic         clk;
    logic         rst;
    logic [W-1:0] inc_in;
    logic [W-1:0] inc_out;

    int total;
    int bad;

    mc_incn_r #(
        .incN_width (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .inc_in  (inc_in),
        .inc_out (inc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic [W-1:0] din;
        int           edges;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Compare one observed output against its expected value
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    logic [W-1:0] fb_exp [3];
    logic [W-1:0] v;

    initial begin
        total = 0;
        bad   = 0;

        // Held operands, checked one edge after they are applied and again while held
        vecs.push_back('{"zero_1",     1'b0, 24'h000000, 1, 24'h000001});
        vecs.push_back('{"zero_hold",  1'b0, 24'h000000, 3, 24'h000001});
        vecs.push_back('{"carry_split",1'b0, 24'h000FFF, 1, 24'h001000});
        vecs.push_back('{"carry_hold", 1'b0, 24'h000FFF, 2, 24'h001000});
        vecs.push_back('{"wrap",       1'b0, 24'hFFFFFF, 1, 24'h000000});
        vecs.push_back('{"msb_carry",  1'b0, 24'h7FFFFF, 1, 24'h800000});
        vecs.push_back('{"mid_carry",  1'b0, 24'hABCFFF, 1, 24'hABD000});
        vecs.push_back('{"lo_only",    1'b0, 24'h000123, 1, 24'h000124});
        vecs.push_back('{"hi_set",     1'b0, 24'hFFF000, 1, 24'hFFF001});
        vecs.push_back('{"lo_allbut",  1'b0, 24'h000FFE, 1, 24'h000FFF});
`ifdef MC_INCN_FULL_REG_EN
        vecs.push_back('{"rst_vec",    1'b1, 24'hABCDEF, 1, 24'h000000});
`else
        vecs.push_back('{"rst_vec",    1'b1, 24'hABCDEF, 1, 24'hABC000});
`endif
        vecs.push_back('{"after_rst",  1'b0, 24'hABCDEF, 1, 24'hABCDF0});

        // Reset state: rst held with a nonzero operand
        rst    = 1'b1;
        inc_in = 24'h123456;
        step(1);
`ifdef MC_INCN_FULL_REG_EN
        chk("reset_state", inc_out, 24'h000000);
`else
        chk("reset_state", inc_out, 24'h123000);
`endif
        step(1);
`ifdef MC_INCN_FULL_REG_EN
        chk("reset_hold", inc_out, 24'h000000);
`else
        chk("reset_hold", inc_out, 24'h123000);
`endif
        rst = 1'b0;
        step(1);
        chk("reset_release", inc_out, 24'h123457);

        // Table-driven vectors, inputs changed on the falling edge
        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            inc_in = vecs[i].din;
            step(vecs[i].edges);
            chk(vecs[i].name, inc_out, vecs[i].exp);
        end
        rst = 1'b0;

        // Upper half path: change only the upper bits between edges
        inc_in = 24'h000FFF;
        step(2);
        chk("pre_comb", inc_out, 24'h001000);
        inc_in = 24'h555FFF;
        #1;
`ifdef MC_INCN_FULL_REG_EN
        chk("comb_upper", inc_out, 24'h001000);
`else
        chk("comb_upper", inc_out, 24'h556000);
`endif
        step(1);
        chk("comb_settled", inc_out, 24'h556000);

        // Mid-operation reset, then recovery one edge after release
        inc_in = 24'hFFFFFF;
        step(1);
        chk("pre_midrst", inc_out, 24'h000000);
        rst = 1'b1;
        step(1);
`ifdef MC_INCN_FULL_REG_EN
        chk("midrst", inc_out, 24'h000000);
`else
        chk("midrst", inc_out, 24'hFFF000);
`endif
        rst = 1'b0;
        step(1);
        chk("midrst_release", inc_out, 24'h000000);
        inc_in = 24'h0ABFFF;
        step(1);
        chk("midrst_next", inc_out, 24'h0AC000);

        // Feedback counter: inc_in takes inc_out every second cycle
        fb_exp[0] = 24'h000FFF;
        fb_exp[1] = 24'h001000;
        fb_exp[2] = 24'h001001;
        inc_in = 24'h000FFE;
        for (int k = 0; k < 3; k++) begin
            step(1);
            v = inc_out;
            chk($sformatf("feedback_%0d", k), v, fb_exp[k]);
            step(1);
            inc_in = v;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mc_incn_r
